// File: rtl/nn_pkg.sv
// Shared constants, state encoding and tag type for the output-layer datapath.
// PIPE_LAT_DEF must track the neuron_out pipeline: multiplier, adder tree, sigmoid LUT.
package nn_pkg;

  localparam int N_IN         = 14;
  localparam int W            = 17;
  localparam int IDX_W        = 4;
  localparam int VEC_W        = N_IN * W;
  localparam logic [W-1:0] Q_ONE = 17'h01000;

  localparam int MUL_LAT      = 3;
  localparam int ADD_STAGES   = 4;
  localparam int LUT_STAGES   = 1;
  localparam int PIPE_LAT_DEF = MUL_LAT + ADD_STAGES + LUT_STAGES;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  function automatic logic wr_in_range(input logic [IDX_W-1:0] out_i,
                                       input logic [IDX_W-1:0] lane_i,
                                       input int               n_out);
    return (int'(out_i) < n_out) && (int'(lane_i) < N_IN);
  endfunction

endpackage

// File: rtl/out_layer_feeder_if.sv
// Activation stream, weight-write port, neuron_out connection and tagged result bus.
// slave is the feeder side; master is the surrounding logic / neuron_out side.
interface out_layer_feeder_if;
  import nn_pkg::*;

  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;

  logic             wr_en;
  logic [IDX_W-1:0] wr_out;
  logic [IDX_W-1:0] wr_idx;
  logic [W-1:0]     wr_data;
  logic             wr_drop;

  logic [VEC_W-1:0] x_o;
  logic [VEC_W-1:0] w_o;
  logic             ce_o;
  logic [W-1:0]     y_i;

  logic             res_valid;
  logic [IDX_W-1:0] res_idx;
  logic [W-1:0]     res_data;
  logic             res_last;
  logic             busy;

  modport slave (
    input  in_valid, in_data, wr_en, wr_out, wr_idx, wr_data, y_i,
    output in_ready, wr_drop, x_o, w_o, ce_o, res_valid, res_idx, res_data, res_last, busy
  );

  modport master (
    output in_valid, in_data, wr_en, wr_out, wr_idx, wr_data, y_i,
    input  in_ready, wr_drop, x_o, w_o, ce_o, res_valid, res_idx, res_data, res_last, busy
  );

endinterface

// File: rtl/tag_delay.sv
// Fixed-depth shift register carrying {valid, idx} alongside the neuron_out pipeline.
// Latency DEPTH cycles, never stalls; synchronous clear while rst_n is low.
module tag_delay
  import nn_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t line_q [DEPTH];
  tag_t line_d [DEPTH];

  always_comb begin
    line_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q <= line_d;
    end
  end

  assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/out_layer_feeder.sv
// Collects 14 activations, then issues one output neuron per cycle into neuron_out and tags results.
// Results PIPE_LAT cycles after issue; in_ready low for N_OUT+PIPE_LAT cycles per sample, no output stall.
module out_layer_feeder
  import nn_pkg::*;
#(
  parameter int N_OUT    = 10,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  out_layer_feeder_if.slave bus
);

  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [IDX_W-1:0] K_LAST    = IDX_W'(N_OUT - 1);
  localparam logic [IDX_W-1:0] LANE_LAST = IDX_W'(N_IN - 1);
  localparam logic [DW-1:0]    D_LAST    = DW'(PIPE_LAT - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             ce_q, ce_d;
  logic             wr_drop_q, wr_drop_d;

  logic [W-1:0]     col_q  [N_IN];
  logic [W-1:0]     col_d  [N_IN];
  logic [W-1:0]     x_q    [N_IN];
  logic [W-1:0]     x_d    [N_IN];
  logic [W-1:0]     bank_q [N_OUT][N_IN];
  logic [W-1:0]     bank_d [N_OUT][N_IN];

  logic             in_hs;
  logic             wr_ok;
  logic [OW-1:0]    w_row;
  logic [VEC_W-1:0] x_vec;
  logic [VEC_W-1:0] w_vec;
  tag_t             tag_in;
  tag_t             tag_out;

  // ce_q doubles as a registered copy of rst_n, keeping in_ready low through reset.
  assign bus.in_ready = ce_q && (state_q == ST_COLLECT);
  assign in_hs        = bus.in_valid && bus.in_ready;
  assign wr_ok        = bus.wr_en && (state_q != ST_ISSUE)
                        && wr_in_range(bus.wr_out, bus.wr_idx, N_OUT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    dcnt_d    = dcnt_q;
    col_d     = col_q;
    x_d       = x_q;
    ce_d      = 1'b1;
    wr_drop_d = bus.wr_en && !wr_ok;
    unique case (state_q)
      ST_COLLECT: begin
        if (in_hs) begin
          col_d[cnt_q] = bus.in_data;
          if (cnt_q == LANE_LAST) begin
            // The 14th word bypasses col_q so the full vector is on x_o in the first ISSUE cycle.
            for (int i = 0; i < N_IN - 1; i++) begin
              x_d[i] = col_q[i];
            end
            x_d[N_IN-1] = bus.in_data;
            cnt_d       = '0;
            k_d         = '0;
            state_d     = ST_ISSUE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_ISSUE: begin
        if (k_q == K_LAST) begin
          k_d     = '0;
          dcnt_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == D_LAST) begin
          dcnt_d  = '0;
          state_d = ST_COLLECT;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // Range check in wr_ok guarantees the row index fits before truncation.
  always_comb begin
    bank_d = bank_q;
    if (wr_ok) begin
      bank_d[bus.wr_out[OW-1:0]][bus.wr_idx] = bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      cnt_q     <= '0;
      k_q       <= '0;
      dcnt_q    <= '0;
      ce_q      <= 1'b0;
      wr_drop_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      dcnt_q    <= dcnt_d;
      ce_q      <= ce_d;
      wr_drop_q <= wr_drop_d;
      x_q       <= x_d;
    end
  end

  // Partial samples are discarded by clearing cnt_q; the bank survives reset.
  always_ff @(posedge clk) begin
    col_q  <= col_d;
    bank_q <= bank_d;
  end

  assign w_row = (state_q == ST_ISSUE) ? k_q[OW-1:0] : '0;

  always_comb begin
    x_vec = '0;
    w_vec = '0;
    for (int i = 0; i < N_IN; i++) begin
      x_vec[i*W +: W] = x_q[i];
      w_vec[i*W +: W] = bank_q[w_row][i];
    end
  end

  assign bus.x_o     = x_vec;
  assign bus.w_o     = w_vec;
  assign bus.ce_o    = ce_q;
  assign bus.wr_drop = wr_drop_q;
  assign bus.busy    = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

  assign tag_in.vld = (state_q == ST_ISSUE);
  assign tag_in.idx = (state_q == ST_ISSUE) ? k_q : '0;

  tag_delay #(
    .DEPTH (PIPE_LAT)
  ) u_tag_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.res_valid = tag_out.vld;
  assign bus.res_idx   = tag_out.idx;
  assign bus.res_data  = bus.y_i;
  assign bus.res_last  = tag_out.vld && (tag_out.idx == K_LAST);

endmodule

// File: tb/tb_out_layer_feeder.sv
// Bench for out_layer_feeder with a behavioural neuron_out stand-in and a result scoreboard.
module tb_out_layer_feeder;
  import nn_pkg::*;

  localparam int N_OUT    = 10;
  localparam int PIPE_LAT = 8;
  localparam int PERIOD   = N_IN + N_OUT + PIPE_LAT;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     data;
    logic             last;
    int               cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 0;

  exp_t         sb [$];
  logic [W-1:0] tb_bank [16][N_IN];
  logic [W-1:0] pipe [PIPE_LAT];

  bit               cw_en = 0;
  logic [IDX_W-1:0] cw_out, cw_idx;
  logic [W-1:0]     cw_data;

  out_layer_feeder_if bus ();

  out_layer_feeder #(
    .N_OUT    (N_OUT),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in sigmoid table: distinct value per index.
  function automatic logic [W-1:0] fsig(input int i);
    return W'((i * 37 + 11) & 'h1ffff);
  endfunction

  function automatic logic [W-1:0] nmodel(input logic [VEC_W-1:0] xv, input logic [VEC_W-1:0] wv);
    longint acc;
    longint li;
    acc = 0;
    for (int i = 0; i < N_IN; i++) begin
      acc += longint'($signed(xv[i*W +: W])) * longint'($signed(wv[i*W +: W]));
    end
    li = 1024 + (acc >>> 24);
    if (li < 0) li = 0;
    if (li > 2047) li = 2047;
    return fsig(int'(li));
  endfunction

  always @(posedge clk) begin
    pipe[0] <= nmodel(bus.x_o, bus.w_o);
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.y_i = pipe[PIPE_LAT-1];

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.res_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result cyc=%0d idx=%0d data=%h", cyc, bus.res_idx, bus.res_data);
        end else begin
          e = sb.pop_front();
          if (bus.res_idx !== e.idx || bus.res_data !== e.data || bus.res_last !== e.last || cyc != e.cyc) begin
            failures++;
            $display("FAIL result got idx=%0d data=%h last=%b cyc=%0d exp idx=%0d data=%h last=%b cyc=%0d",
                     bus.res_idx, bus.res_data, bus.res_last, cyc, e.idx, e.data, e.last, e.cyc);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        checks++;
        failures++;
        e = sb.pop_front();
        $display("FAIL missing_result idx=%0d exp_cyc=%0d now=%0d", e.idx, e.cyc, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [W-1:0] v [N_IN], input int hs_cyc);
    logic [VEC_W-1:0] xv, wv;
    exp_t e;
    for (int i = 0; i < N_IN; i++) xv[i*W +: W] = v[i];
    for (int k = 0; k < N_OUT; k++) begin
      for (int i = 0; i < N_IN; i++) wv[i*W +: W] = tb_bank[k][i];
      e.idx  = IDX_W'(k);
      e.data = nmodel(xv, wv);
      e.last = (k == N_OUT - 1);
      e.cyc  = hs_cyc + 1 + k + PIPE_LAT;
      sb.push_back(e);
    end
  endtask

  // Returns at #1 in the first ISSUE cycle; cw_* adds a write on the 14th handshake cycle.
  task automatic send_sample(input logic [W-1:0] v [N_IN], input int gap, output int hs_cyc);
    int wait_n;
    hs_cyc = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (i % 3 == 1) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          step();
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v[i];
      wait_n = 0;
      while (bus.in_ready !== 1'b1 && wait_n < 200) begin
        step();
        wait_n++;
      end
      if (wait_n >= 200) begin
        checks++;
        failures++;
        $display("FAIL in_ready_timeout lane=%0d got=%b exp=1", i, bus.in_ready);
      end
      if (i == N_IN - 1 && cw_en) begin
        bus.wr_en   = 1'b1;
        bus.wr_out  = cw_out;
        bus.wr_idx  = cw_idx;
        bus.wr_data = cw_data;
      end
      hs_cyc = cyc;
      step();
    end
    bus.in_valid = 1'b0;
    if (cw_en) begin
      bus.wr_en = 1'b0;
      tb_bank[cw_out][cw_idx] = cw_data;
      cw_en = 0;
    end
    push_expect(v, hs_cyc);
  endtask

  task automatic do_write(input logic [IDX_W-1:0] o, input logic [IDX_W-1:0] l,
                          input logic [W-1:0] d, output logic drop);
    bus.wr_en   = 1'b1;
    bus.wr_out  = o;
    bus.wr_idx  = l;
    bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
    drop = bus.wr_drop;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout pending=%0d busy=%b exp pending=0 busy=0", sb.size(), bus.busy);
      sb.delete();
    end
    step();
  endtask

  task automatic rand_vec(output logic [W-1:0] v [N_IN]);
    for (int i = 0; i < N_IN; i++) v[i] = W'($urandom_range(0, 'h4000)) - 17'h02000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks += 6;
    if (bus.in_ready !== 1'b0)  begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    if (bus.busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid got=%b exp=0", bus.res_valid); end
    if (bus.wr_drop !== 1'b0)   begin failures++; $display("FAIL rst_wr_drop got=%b exp=0", bus.wr_drop); end
    if (bus.ce_o !== 1'b0)      begin failures++; $display("FAIL rst_ce got=%b exp=0", bus.ce_o); end
    if (bus.x_o !== '0)         begin failures++; $display("FAIL rst_x_o got=%h exp=0", bus.x_o); end
    rst_n = 1'b1;
    step();
    checks += 3;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
    if (bus.ce_o !== 1'b1)     begin failures++; $display("FAIL post_rst_ce got=%b exp=1", bus.ce_o); end
    if (bus.res_last !== 1'b0) begin failures++; $display("FAIL post_rst_res_last got=%b exp=0", bus.res_last); end
    mon_en = 1;
  endtask

  task automatic test_basic();
    logic [W-1:0] v [N_IN];
    logic drop;
    int   drops, hs;
    drops = 0;
    for (int o = 0; o < N_OUT; o++) begin
      for (int l = 0; l < N_IN; l++) begin
        tb_bank[o][l] = (o == 0 && l == 0) ? Q_ONE : '0;
        do_write(IDX_W'(o), IDX_W'(l), tb_bank[o][l], drop);
        if (drop !== 1'b0) drops++;
      end
    end
    checks++;
    if (drops != 0) begin failures++; $display("FAIL init_writes dropped=%0d exp=0", drops); end
    for (int i = 0; i < N_IN; i++) v[i] = (i == 0) ? Q_ONE : '0;
    send_sample(v, 0, hs);
    wait_idle();
  endtask

  task automatic test_handshake_count();
    logic [W-1:0] v [N_IN];
    int hs, low_n;
    bit busy_ok;
    logic drop;
    for (int o = 0; o < N_OUT; o++) begin
      for (int l = 0; l < N_IN; l++) begin
        tb_bank[o][l] = W'($urandom_range(0, 'h4000)) - 17'h02000;
        do_write(IDX_W'(o), IDX_W'(l), tb_bank[o][l], drop);
      end
    end
    rand_vec(v);
    send_sample(v, 2, hs);
    low_n = 0;
    busy_ok = 1;
    while (bus.in_ready !== 1'b1 && low_n < 100) begin
      if (bus.busy !== 1'b1) busy_ok = 0;
      low_n++;
      step();
    end
    checks += 3;
    if (low_n != N_OUT + PIPE_LAT) begin failures++; $display("FAIL ready_low_cycles got=%0d exp=%0d", low_n, N_OUT + PIPE_LAT); end
    if (!busy_ok)                  begin failures++; $display("FAIL busy_window got=0 exp=1"); end
    if (bus.busy !== 1'b0)         begin failures++; $display("FAIL busy_after got=%b exp=0", bus.busy); end
    wait_idle();
  endtask

  task automatic test_dropped_writes();
    logic [W-1:0] v [N_IN];
    logic drop;
    int hs;
    for (int i = 0; i < N_IN; i++) v[i] = Q_ONE;
    send_sample(v, 0, hs);
    do_write(4'd1, 4'd0, 17'h03000, drop);
    checks++;
    if (drop !== 1'b1) begin failures++; $display("FAIL drop_in_issue got=%b exp=1", drop); end
    wait_idle();
    do_write(4'd2, 4'd14, 17'h03000, drop);
    checks++;
    if (drop !== 1'b1) begin failures++; $display("FAIL drop_lane14 got=%b exp=1", drop); end
    step();
    checks++;
    if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL drop_pulse_width got=%b exp=0", bus.wr_drop); end
    do_write(4'd12, 4'd0, 17'h03000, drop);
    checks++;
    if (drop !== 1'b1) begin failures++; $display("FAIL drop_out12 got=%b exp=1", drop); end
    do_write(4'd2, 4'd13, 17'h01800, drop);
    tb_bank[2][13] = 17'h01800;
    checks++;
    if (drop !== 1'b0) begin failures++; $display("FAIL accept_write got=%b exp=0", drop); end
    // Write coincident with the COLLECT->ISSUE edge lands in this sample.
    cw_en = 1; cw_out = 4'd7; cw_idx = 4'd2; cw_data = 17'h1e000;
    send_sample(v, 1, hs);
    checks++;
    if (bus.wr_drop !== 1'b0) begin failures++; $display("FAIL edge_write_drop got=%b exp=0", bus.wr_drop); end
    wait_idle();
  endtask

  task automatic test_write_timing();
    logic [W-1:0] v [N_IN];
    logic drop;
    int hs;
    for (int i = 0; i < N_IN; i++) v[i] = (i == 5) ? 17'h02000 : 17'h00800;
    send_sample(v, 0, hs);
    repeat (N_OUT) step();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL in_drain_busy got=%b exp=1", bus.busy); end
    do_write(4'd3, 4'd5, 17'h04000, drop);
    checks++;
    if (drop !== 1'b0) begin failures++; $display("FAIL drain_write got=%b exp=0", drop); end
    tb_bank[3][5] = 17'h04000;
    send_sample(v, 0, hs);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v [N_IN];
    int hs, seen;
    rand_vec(v);
    send_sample(v, 0, hs);
    repeat (4) step();
    sb.delete();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL in_ready_in_reset got=%b exp=0", bus.in_ready); end
    seen = 0;
    for (int c = 0; c < PIPE_LAT + 1; c++) begin
      if (bus.res_valid !== 1'b0) seen++;
      step();
    end
    checks += 2;
    if (seen != 0)         begin failures++; $display("FAIL stale_res_valid got=%0d exp=0", seen); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after_reset got=%b exp=0", bus.busy); end
    rand_vec(v);
    send_sample(v, 0, hs);
    wait_idle();
    // Partial sample in COLLECT is discarded by reset.
    bus.in_valid = 1'b1;
    bus.in_data  = 17'h1ffff;
    repeat (5) step();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    rand_vec(v);
    send_sample(v, 0, hs);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] v [N_IN];
    int hs [3];
    for (int s = 0; s < 3; s++) begin
      rand_vec(v);
      send_sample(v, 0, hs[s]);
    end
    checks += 2;
    if (hs[1] - hs[0] != PERIOD) begin failures++; $display("FAIL b2b_period0 got=%0d exp=%0d", hs[1] - hs[0], PERIOD); end
    if (hs[2] - hs[1] != PERIOD) begin failures++; $display("FAIL b2b_period1 got=%0d exp=%0d", hs[2] - hs[1], PERIOD); end
    wait_idle();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wr_en    = 1'b0;
    bus.wr_out   = '0;
    bus.wr_idx   = '0;
    bus.wr_data  = '0;
    rst_n        = 1'b0;
    for (int o = 0; o < 16; o++) for (int l = 0; l < N_IN; l++) tb_bank[o][l] = '0;
    test_reset();
    test_basic();
    test_handshake_count();
    test_dropped_writes();
    test_write_timing();
    test_reset_mid();
    test_back_to_back();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
